// File: rtl/rfdp_pkg.sv
// Shared definitions for the rfdp buffer sequencers (reader now, writer later).
package rfdp_pkg;

    typedef enum logic [1:0] {
        RFDP_IDLE  = 2'd0,
        RFDP_RUN   = 2'd1,
        RFDP_DRAIN = 2'd2
    } rfdp_rd_state_e;

    // Compare-and-clear wrap so non power-of-two depths step correctly.
    function automatic int unsigned rfdp_addr_inc(input int unsigned addr,
                                                  input int unsigned depth);
        return (addr == depth - 32'd1) ? 32'd0 : addr + 32'd1;
    endfunction

endpackage

// File: rtl/rfdp_rd_streamer_if.sv
// Buffer read port plus outgoing valid/ready stream of the rfdp read streamer.
interface rfdp_rd_streamer_if #(
    parameter int WIDTH = 256,
    parameter int AW    = 10
);
    logic [AW-1:0]    aa;
    logic             cena;
    logic [WIDTH-1:0] qa;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             m_ready;

    modport master (output aa, cena, m_valid, m_data, m_last,
                    input  qa, m_ready);
    modport slave  (input  aa, cena, m_valid, m_data, m_last,
                    output qa, m_ready);
endinterface

// File: rtl/rfdp_skid_fifo.sv
// Two-entry register FIFO; the head entry drives the outputs directly from flops.
module rfdp_skid_fifo #(
    parameter int W = 257
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [W-1:0] rd_data,
    output logic [1:0]   occ
);
    import rfdp_pkg::*;

    logic [W-1:0] d0_q, d0_d, d1_q, d1_d;
    logic [1:0]   occ_q, occ_d;
    logic         pop;

    always_comb begin
        pop   = (occ_q != 2'd0) && rd_ready;
        d0_d  = d0_q;
        d1_d  = d1_q;
        occ_d = occ_q;
        case ({wr_en, pop})
            2'b10: begin
                if (occ_q == 2'd0) d0_d = wr_data;
                else               d1_d = wr_data;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                if (occ_q == 2'd2) d0_d = d1_q;
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    d0_d = d1_q;
                    d1_d = wr_data;
                end else begin
                    d0_d = wr_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= 2'd0;
            d0_q  <= '0;
        end else begin
            occ_q <= occ_d;
            d0_q  <= d0_d;
        end
    end

    // The second slot is only ever read after being written.
    always_ff @(posedge clk) begin
        d1_q <= d1_d;
    end

    assign rd_valid = (occ_q != 2'd0);
    assign rd_data  = d0_q;
    assign occ      = occ_q;
endmodule

// File: rtl/rfdp_rd_streamer.sv
// Walks a wrap-around range of an rfdp read port and re-times the data into a stream.
module rfdp_rd_streamer #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AW-1:0]     base_addr,
    input  logic [AW:0]       len,
    output logic              busy,
    output logic              done,
    rfdp_rd_streamer_if.master bus
);
    import rfdp_pkg::*;

    localparam logic [1:0] S_IDLE  = RFDP_IDLE;
    localparam logic [1:0] S_RUN   = RFDP_RUN;
    localparam logic [1:0] S_DRAIN = RFDP_DRAIN;
    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d, aa_q, aa_d;
    logic [AW:0]   issue_cnt_q, issue_cnt_d, pop_cnt_q, pop_cnt_d;
    logic          inflight_q, inflight_d, inflight_last_q, inflight_last_d;
    logic          busy_q, busy_d, done_q, done_d;

    logic [1:0]    occ;
    logic          f_valid;
    logic [WIDTH:0] f_data;
    logic          pop, credit_ok, issue;

    assign pop = f_valid && bus.m_ready;
    // A pop this cycle frees its slot in time for the read issued alongside it.
    assign credit_ok = ({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    assign issue = (state_q == S_RUN) && (issue_cnt_q != '0) && credit_ok;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        aa_d            = aa_q;
        issue_cnt_d     = issue_cnt_q;
        pop_cnt_d       = pop_cnt_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        inflight_d      = issue;
        inflight_last_d = issue && (issue_cnt_q == CNT_ONE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        addr_d      = base_addr;
                        issue_cnt_d = len;
                        pop_cnt_d   = len;
                        busy_d      = 1'b1;
                        state_d     = S_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (issue) begin
                    aa_d        = addr_q;
                    addr_d      = AW'(rfdp_addr_inc(32'(addr_q), 32'(DEPTH)));
                    issue_cnt_d = issue_cnt_q - CNT_ONE;
                    if (issue_cnt_q == CNT_ONE) state_d = S_DRAIN;
                end
            end
            default: ;
        endcase

        if (pop) pop_cnt_d = pop_cnt_q - CNT_ONE;
        if (pop && (pop_cnt_q == CNT_ONE) && (state_q == S_DRAIN)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            aa_q            <= '0;
            issue_cnt_q     <= '0;
            pop_cnt_q       <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            aa_q            <= aa_d;
            issue_cnt_q     <= issue_cnt_d;
            pop_cnt_q       <= pop_cnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    rfdp_skid_fifo #(.W(WIDTH + 1)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (inflight_q),
        .wr_data  ({inflight_last_q, bus.qa}),
        .rd_valid (f_valid),
        .rd_ready (bus.m_ready),
        .rd_data  (f_data),
        .occ      (occ)
    );

    assign bus.cena    = !issue;
    assign bus.aa      = issue ? addr_q : aa_q;
    assign bus.m_valid = f_valid;
    assign bus.m_data  = f_data[WIDTH-1:0];
    assign bus.m_last  = f_data[WIDTH];
    assign busy        = busy_q;
    assign done        = done_q;
endmodule

// File: tb/tb_rfdp_rd_streamer.sv
// Scoreboard bench for rfdp_rd_streamer: one 1024-deep and one 24-deep instance.
module tb_rfdp_rd_streamer;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [W-1:0] patA(input logic [9:0] a);
        return 32'hA5A5_0000 | 32'(a);
    endfunction
    function automatic logic [W-1:0] patB(input logic [4:0] a);
        return 32'h5B00_0000 | 32'(a);
    endfunction

    // ---------------- instance A: DEPTH 1024 ----------------
    logic       startA, busyA, doneA;
    logic [9:0] baseA;
    logic [10:0] lenA;
    rfdp_rd_streamer_if #(.WIDTH(W), .AW(10)) ifA ();
    rfdp_rd_streamer #(.DEPTH(1024), .WIDTH(W)) dutA (
        .clk(clk), .rst(rst), .start(startA), .base_addr(baseA), .len(lenA),
        .busy(busyA), .done(doneA), .bus(ifA.master));
    always @(posedge clk) if (!ifA.cena) ifA.qa <= patA(ifA.aa);

    // ---------------- instance B: DEPTH 24 ----------------
    logic       startB, busyB, doneB;
    logic [4:0] baseB;
    logic [5:0] lenB;
    rfdp_rd_streamer_if #(.WIDTH(W), .AW(5)) ifB ();
    rfdp_rd_streamer #(.DEPTH(24), .WIDTH(W)) dutB (
        .clk(clk), .rst(rst), .start(startB), .base_addr(baseB), .len(lenB),
        .busy(busyB), .done(doneB), .bus(ifB.master));
    always @(posedge clk) if (!ifB.cena) ifB.qa <= patB(ifB.aa);

    // ---------------- scoreboards and monitors ----------------
    logic [W:0] expA[$];
    logic [W:0] expB[$];
    int         issA, popA;
    logic       stallA;
    logic [W:0] heldA;

    always @(negedge clk) begin
        if (rst) begin
            issA = 0; popA = 0; stallA = 1'b0;
        end else begin
            if (stallA)
                chk("A_stall_hold", {31'd0, ifA.m_valid, ifA.m_last, ifA.m_data}, {31'd0, 1'b1, heldA});
            if (!ifA.cena) issA++;
            if (ifA.m_valid && ifA.m_ready) begin
                popA++;
                if (expA.size() == 0) chk("A_extra_word", {31'd0, ifA.m_last, ifA.m_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                else chk("A_word", {31'd0, ifA.m_last, ifA.m_data}, {31'd0, expA.pop_front()});
            end
            if (!ifA.cena) chk("A_credit", 64'(issA - popA <= 2), 64'd1);
            stallA = ifA.m_valid && !ifA.m_ready;
            heldA  = {ifA.m_last, ifA.m_data};
        end
    end

    always @(negedge clk) begin
        if (!rst && ifB.m_valid && ifB.m_ready) begin
            if (expB.size() == 0) chk("B_extra_word", {31'd0, ifB.m_last, ifB.m_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("B_word", {31'd0, ifB.m_last, ifB.m_data}, {31'd0, expB.pop_front()});
        end
    end

    // ---------------- helpers ----------------
    task automatic chk_rstA(input string nm);
        chk(nm, {17'd0, busyA, doneA, ifA.cena, ifA.aa, ifA.m_valid, ifA.m_last, ifA.m_data},
                {17'd0, 1'b0, 1'b0, 1'b1, 10'h0, 1'b0, 1'b0, 32'h0});
    endtask

    task automatic runA(input logic [9:0] b, input logic [10:0] n, input bit tog,
                        output int t0, output int tv, output int td, output int nis);
        for (int i = 0; i < int'(n); i++)
            expA.push_back({(i == int'(n) - 1), patA(10'((int'(b) + i) % 1024))});
        @(posedge clk); #1;
        startA = 1'b1; baseA = b; lenA = n; t0 = cyc;
        tv = -1; td = -1; nis = 0;
        for (int k = 0; k < 200 && td < 0; k++) begin
            @(negedge clk);
            if (ifA.m_valid && tv < 0) tv = cyc;
            if (!ifA.cena) nis++;
            if (doneA) td = cyc;
            @(posedge clk); #1;
            startA = 1'b0;
            ifA.m_ready = tog ? ~ifA.m_ready : 1'b1;
        end
        if (td < 0) chk("A_done_timeout", 64'd0, 64'd1);
        ifA.m_ready = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int t0, tv, td, nis, nd;
    int dB[2];

    initial begin
        rst = 1'b1;
        startA = 1'b0; baseA = '0; lenA = '0; ifA.m_ready = 1'b1;
        startB = 1'b0; baseB = '0; lenB = '0; ifB.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_rstA("A_reset_values");
        chk("B_reset_values", {56'd0, busyB, doneB, ifB.cena, ifB.m_valid, ifB.m_last, 3'd0},
                              {56'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0});
        @(posedge clk); #1 rst = 1'b0;

        // base 0x010, len 4, ready high
        runA(10'h010, 11'd4, 1'b0, t0, tv, td, nis);
        chk("A_first_valid_lat", 64'(tv - t0), 64'd3);
        chk("A_done_lat", 64'(td - t0), 64'd7);
        chk("A_q_empty_1", 64'(expA.size()), 64'd0);
        @(negedge clk);
        chk("A_done_one_pulse", {63'd0, doneA}, 64'd0);
        chk("A_busy_after_done", {63'd0, busyA}, 64'd0);

        // wrap across the top of a 1024-word buffer
        runA(10'h3FE, 11'd4, 1'b0, t0, tv, td, nis);
        chk("A_wrap_done_lat", 64'(td - t0), 64'd7);
        chk("A_q_empty_2", 64'(expA.size()), 64'd0);

        // ready toggling every cycle
        runA(10'h100, 11'd8, 1'b1, t0, tv, td, nis);
        chk("A_toggle_issues", 64'(nis), 64'd8);
        chk("A_q_empty_3", 64'(expA.size()), 64'd0);

        // zero-length start
        runA(10'h055, 11'd0, 1'b0, t0, tv, td, nis);
        chk("A_len0_done_lat", 64'(td - t0), 64'd1);
        chk("A_len0_no_valid", 64'(tv), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("A_len0_no_issue", 64'(nis), 64'd0);

        // reset two cycles into a 16-word transfer
        @(posedge clk); #1;
        startA = 1'b1; baseA = 10'h200; lenA = 11'd16; t0 = cyc;
        @(posedge clk); #1 startA = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_rstA("A_reset_mid_xfer");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("A_post_rst_quiet", {62'd0, doneA, ifA.m_valid}, 64'd0);
        end
        runA(10'h005, 11'd2, 1'b0, t0, tv, td, nis);
        chk("A_after_rst_done_lat", 64'(td - t0), 64'd5);
        chk("A_q_empty_4", 64'(expA.size()), 64'd0);

        // DEPTH 24: full-length wrap, ignored start in RUN, start in done cycle
        for (int i = 0; i < 24; i++)
            expB.push_back({(i == 23), patB(5'((22 + i) % 24))});
        expB.push_back({1'b0, patB(5'd3)});
        expB.push_back({1'b1, patB(5'd4)});
        @(posedge clk); #1;
        startB = 1'b1; baseB = 5'd22; lenB = 6'd24; t0 = cyc;
        nd = 0;
        for (int k = 0; k < 100 && nd < 2; k++) begin
            @(negedge clk);
            if (doneB) begin dB[nd] = cyc; nd++; end
            @(posedge clk); #1;
            if (cyc == t0 + 3) begin
                startB = 1'b1; baseB = 5'd5; lenB = 6'd3;
            end else if (cyc == t0 + 27) begin
                startB = 1'b1; baseB = 5'd3; lenB = 6'd2;
            end else begin
                startB = 1'b0;
            end
        end
        startB = 1'b0;
        if (nd < 2) chk("B_done_timeout", 64'(nd), 64'd2);
        else begin
            chk("B_full_done_lat", 64'(dB[0] - t0), 64'd27);
            chk("B_back2back_done_lat", 64'(dB[1] - t0), 64'd32);
        end
        repeat (4) @(negedge clk);
        chk("B_q_empty", 64'(expB.size()), 64'd0);
        chk("A_q_empty_final", 64'(expA.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
